// File: rtl/cfg_pkg.sv
// -----------------------------------------------------------------------------
// cfg_pkg
// Shared types and defaults for the serial configuration loader.
//   CFG_W_DEF       default config bits per logic block (4 mux4to1 inputs +
//                   1 mux2to1 select)
//   NUM_BLOCKS_DEF  default number of logic blocks programmed per load
//   loader_state_t  loader FSM encoding (also exported on the debug port)
//   cfg_word_t      one default-width config word
// -----------------------------------------------------------------------------
package cfg_pkg;

  localparam int CFG_W_DEF      = 5;
  localparam int NUM_BLOCKS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  typedef logic [CFG_W_DEF-1:0] cfg_word_t;

  // Even parity over data + parity bit: the running XOR of the data bits
  // combined with the received parity bit must come out 0.
  function automatic logic even_parity_ok(input logic acc, input logic pbit);
    return ~(acc ^ pbit);
  endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// -----------------------------------------------------------------------------
// cfg_word_assembler
// Serial-in, LSB-first word assembler with bit counter and parity accumulator.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   clear      in   restart assembly at bit 0 (new load)
//   shift_en   in   a bit is accepted this cycle
//   bit_in     in   serial data bit
//   word_full  out  this accept completes the word (combinational)
//   parity_ok  out  received parity bit matches even parity (valid with
//                   word_full when PARITY_EN)
//   word       out  assembled word including the bit accepted this cycle
// With PARITY_EN the word is CFG_W data bits followed by one parity bit, so
// the counter runs 0..CFG_W; otherwise it runs 0..CFG_W-1.
// -----------------------------------------------------------------------------
module cfg_word_assembler
  import cfg_pkg::*;
#(
  parameter int CFG_W     = CFG_W_DEF,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic             word_full,
  output logic             parity_ok,
  output logic [CFG_W-1:0] word
);

  localparam int CW = $clog2(CFG_W + 1);
  localparam logic [CW-1:0] LAST_IDX = PARITY_EN ? CW'(CFG_W) : CW'(CFG_W - 1);

  logic [CFG_W-1:0] shift_q;
  logic [CW-1:0]    bit_idx;
  logic             par_q;

  // The word is presented with the incoming bit already merged so the loader
  // can register it on the same edge that accepts the last data bit. The
  // parity bit (bit_idx == CFG_W) never lands in the data field.
  always_comb begin
    word = shift_q;
    for (int i = 0; i < CFG_W; i++) begin
      if (shift_en && (bit_idx == CW'(i))) begin
        word[i] = bit_in;
      end
    end
  end

  assign word_full = shift_en && (bit_idx == LAST_IDX);
  assign parity_ok = even_parity_ok(par_q, bit_in);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      bit_idx <= '0;
      par_q   <= 1'b0;
    end else if (clear) begin
      shift_q <= '0;
      bit_idx <= '0;
      par_q   <= 1'b0;
    end else if (shift_en) begin
      shift_q <= word;
      if (word_full) begin
        bit_idx <= '0;
        par_q   <= 1'b0;
      end else begin
        bit_idx <= bit_idx + CW'(1);
        par_q   <= par_q ^ bit_in;
      end
    end
  end

endmodule

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
// Serial configuration writer for the logic-block config registers. Receives
// a bitstream, assembles one CFG_W-bit word per block and writes it into the
// block register selected by a one-hot strobe.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset (aborts a load at once)
//   start      in   begin a load; honoured only in IDLE/DONE/ERROR
//   bit_in     in   serial config bit, LSB of each word first
//   bit_valid  in   bit_in is valid this cycle
//   bit_ready  out  loader accepts a bit this cycle (high only in SHIFT)
//   cfg_word   out  word to the block registers; holds last written value
//   cfg_we     out  one-hot write strobe, bit i = block i, only in WRITE
//   busy       out  load in progress (SHIFT/WRITE)
//   done       out  all NUM_BLOCKS words written
//   error      out  parity failure; constant 0 without CFG_PARITY_EN
//   state_dbg  out  current FSM state (loader_state_t encoding)
// Handshake: a bit transfers on a rising edge where bit_valid && bit_ready;
//   bit_valid while bit_ready is low is ignored, and the source may stall
//   for any number of cycles.
// Build option: define CFG_PARITY_EN to expect one even-parity bit after each
//   word; a mismatch drops that word and parks the loader in ERROR.
// -----------------------------------------------------------------------------
module config_loader
  import cfg_pkg::*;
#(
  parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
  parameter int CFG_W      = CFG_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  output logic                  bit_ready,
  output logic [CFG_W-1:0]      cfg_word,
  output logic [NUM_BLOCKS-1:0] cfg_we,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);

`ifdef CFG_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [NUM_BLOCKS-1:0] ONE_HOT0 = NUM_BLOCKS'(1);
  localparam logic [BW-1:0]         LAST_BLK = BW'(NUM_BLOCKS - 1);

  loader_state_t    state;
  logic [BW-1:0]    blk_idx;

  logic             accept;
  logic             load_start;
  logic             word_full;
  logic             parity_ok;
  logic             word_bad;
  logic [CFG_W-1:0] word;

  // bit_ready is registered and high exactly while in SHIFT, so the accept
  // term needs no separate state qualifier.
  assign accept     = bit_valid && bit_ready;
  assign load_start = start && ((state == IDLE) || (state == DONE) ||
                                (state == ERROR));
  assign word_bad   = PARITY_EN && !parity_ok;
  assign state_dbg  = state;

  cfg_word_assembler #(
    .CFG_W     (CFG_W),
    .PARITY_EN (PARITY_EN)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (load_start),
    .shift_en  (accept),
    .bit_in    (bit_in),
    .word_full (word_full),
    .parity_ok (parity_ok),
    .word      (word)
  );

  // All outputs are registered and updated on the transition into the state
  // that owns them, so each output lines up with its state cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      blk_idx   <= '0;
      bit_ready <= 1'b0;
      cfg_word  <= '0;
      cfg_we    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cfg_we <= '0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= SHIFT;
            blk_idx   <= '0;
            bit_ready <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
          end
        end
        SHIFT: begin
          if (word_full) begin
            bit_ready <= 1'b0;
            if (word_bad) begin
              // Failed word is dropped: no strobe, cfg_word keeps old value.
              state <= ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state    <= WRITE;
              cfg_word <= word;
              cfg_we   <= ONE_HOT0 << blk_idx;
            end
          end
        end
        WRITE: begin
          if (blk_idx == LAST_BLK) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= SHIFT;
            blk_idx   <= blk_idx + BW'(1);
            bit_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          bit_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          error     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
// Directed bench for config_loader (default build and CFG_PARITY_EN build).
// -----------------------------------------------------------------------------
module tb_config_loader;
  import cfg_pkg::*;

  localparam int NB = 4;
  localparam int CW = 5;
`ifdef CFG_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int WORD_PERIOD = CW + PB + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic [CW-1:0] cfg_word;
  logic [NB-1:0] cfg_we;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  config_loader #(.NUM_BLOCKS(NB), .CFG_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .cfg_word  (cfg_word),
    .cfg_we    (cfg_we),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  // Each entry is {cfg_we, cfg_word} expected for one WRITE cycle, in order.
  logic [NB+CW-1:0] exp_q[$];
  logic [NB+CW-1:0] exp_e;
  int rdy_bad  = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (bit_ready !== (state_dbg == SHIFT)) rdy_bad++;
      if (PB == 0 && error !== 1'b0) err_seen++;
      if (cfg_we !== '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write got we=%b word=%b expected none",
                   cfg_we, cfg_word);
        end else begin
          exp_e = exp_q.pop_front();
          if ({cfg_we, cfg_word} !== exp_e) begin
            errors++;
            $display("FAIL sb_write got we=%b word=%b expected we=%b word=%b",
                     cfg_we, cfg_word, exp_e[NB+CW-1:CW], exp_e[CW-1:0]);
          end
        end
      end
    end
  end

  // Watchdog: the run is a few thousand cycles at most.
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_bit(input logic b, input int gap);
    int tmo;
    bit_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bit_in    = b;
    bit_valid = 1'b1;
    tmo = 0;
    while (bit_ready !== 1'b1 && tmo < 40) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 40) begin
      checks++;
      errors++;
      $display("FAIL bit_ready_timeout got bit_ready=%b expected 1", bit_ready);
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [CW-1:0] w, input int gap_max,
                           input logic par_flip);
    for (int i = 0; i < CW; i++)
      send_bit(w[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    if (PB == 1) send_bit((^w) ^ par_flip, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams one good word for block blk and checks the WRITE cycle that
  // must follow the last accepted bit directly.
  task automatic do_word(input int blk, input logic [CW-1:0] w,
                         input int gap_max);
    logic [NB-1:0] we_exp;
    we_exp = '0;
    we_exp[blk] = 1'b1;
    exp_q.push_back({we_exp, w});
    send_word(w, gap_max, 1'b0);
    checks++;
    if (cfg_we !== we_exp || cfg_word !== w || bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_latency blk%0d got we=%b word=%b rdy=%b expected we=%b word=%b rdy=0",
               blk, cfg_we, cfg_word, bit_ready, we_exp, w);
    end
  endtask

  task automatic check_done(input string tag, input logic [CW-1:0] last_w);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cfg_we !== '0 || cfg_word !== last_w) begin
      errors++;
      $display("FAIL %s_done got done=%b busy=%b we=%b word=%b expected done=1 busy=0 we=0000 word=%b",
               tag, done, busy, cfg_we, cfg_word, last_w);
    end
  endtask

  logic [CW-1:0] words [4] = '{5'b10110, 5'b00001, 5'b11111, 5'b01010};

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bit_ready, cfg_word, cfg_we, busy, done, error} !== '0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b word=%b we=%b busy=%b done=%b err=%b st=%0d expected all 0",
               bit_ready, cfg_word, cfg_we, busy, done, error, state_dbg);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bit_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold got busy=%b rdy=%b expected 0 0", busy, bit_ready);
    end
  endtask

  task automatic test_stream();
    int wc [4];
    pulse_start();
    checks++;
    if (busy !== 1'b1 || bit_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_shift got busy=%b rdy=%b done=%b expected 1 1 0",
               busy, bit_ready, done);
    end
    for (int k = 0; k < 4; k++) begin
      do_word(k, words[k], 0);
      wc[k] = cyc;
    end
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (wc[k] - wc[k-1] != WORD_PERIOD) begin
        errors++;
        $display("FAIL write_spacing blk%0d got %0d cycles expected %0d",
                 k, wc[k] - wc[k-1], WORD_PERIOD);
      end
    end
    check_done("stream", words[3]);
  endtask

  task automatic test_gaps();
    pulse_start();
    for (int k = 0; k < 4; k++) do_word(k, words[k], 7);
    check_done("gaps", words[3]);
  endtask

  task automatic test_reset_abort();
    pulse_start();
    do_word(0, words[0], 0);
    do_word(1, words[1], 0);
    send_bit(words[2][0], 0);
    send_bit(words[2][1], 0);
    bit_valid = 1'b1;
    bit_in    = words[2][2];
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bit_ready, cfg_word, cfg_we, busy, done, error} !== '0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b word=%b we=%b busy=%b done=%b err=%b expected all 0",
               bit_ready, cfg_word, cfg_we, busy, done, error);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    repeat (CW) @(negedge clk);
    bit_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0 || cfg_we !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got pending=%0d we=%b busy=%b expected 0 0000 0",
               exp_q.size(), cfg_we, busy);
    end
    pulse_start();
    for (int k = 0; k < 4; k++) do_word(k, words[k], 2);
    check_done("restart", words[3]);
  endtask

  task automatic test_start_ignored();
    pulse_start();
    exp_q.push_back({4'b0001, words[1]});
    send_bit(words[1][0], 0);
    send_bit(words[1][1], 0);
    pulse_start();
    for (int i = 2; i < CW; i++) send_bit(words[1][i], 0);
    if (PB == 1) send_bit(^words[1], 0);
    checks++;
    if (cfg_we !== 4'b0001 || cfg_word !== words[1]) begin
      errors++;
      $display("FAIL start_in_shift got we=%b word=%b expected 0001 %b",
               cfg_we, cfg_word, words[1]);
    end
    pulse_start();
    checks++;
    if (bit_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_write got rdy=%b busy=%b done=%b expected 1 1 0",
               bit_ready, busy, done);
    end
    do_word(1, words[2], 0);
    do_word(2, words[3], 0);
    do_word(3, words[0], 0);
    check_done("ign", words[0]);
    pulse_start();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1 || bit_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done got done=%b busy=%b rdy=%b expected 0 1 1",
               done, busy, bit_ready);
    end
    for (int k = 0; k < 4; k++) do_word(k, words[3-k], 0);
    check_done("reload", words[0]);
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    pulse_start();
    do_word(0, 5'b10110, 0);
    send_word(5'b00001, 0, 1'b1);
    checks++;
    if (error !== 1'b1 || cfg_we !== '0 || busy !== 1'b0 || bit_ready !== 1'b0 ||
        cfg_word !== 5'b10110) begin
      errors++;
      $display("FAIL parity_error got err=%b we=%b busy=%b rdy=%b word=%b expected 1 0000 0 0 10110",
               error, cfg_we, busy, bit_ready, cfg_word);
    end
    repeat (3) @(negedge clk);
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL error_clear got err=%b busy=%b expected 0 1", error, busy);
    end
    for (int k = 0; k < 4; k++) do_word(k, words[k], 0);
    check_done("par", words[3]);
  endtask
`else
  task automatic test_no_parity();
    pulse_start();
    for (int k = 0; k < 4; k++) do_word(k, words[k], 1);
    check_done("nopar", words[3]);
    checks++;
    if (err_seen != 0) begin
      errors++;
      $display("FAIL error_tied got %0d cycles with error=1 expected 0", err_seen);
    end
  endtask
`endif

  task automatic final_report();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_missing_writes got %0d pending expected 0", exp_q.size());
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++;
      $display("FAIL bit_ready_state got %0d bad cycles expected 0", rdy_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_reset_abort();
    test_start_ignored();
`ifdef CFG_PARITY_EN
    test_parity();
`else
    test_no_parity();
`endif
    final_report();
  end

endmodule
